// File: rtl/cp0_exc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_exc_ctrl_if
//  Description : MEM-stage event inputs, CP0 write port and PC redirect
//                outputs of the exception sequencer, bundled as one bus.
//                Signal suffixes are relative to the sequencer (slave side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface cp0_exc_ctrl_if;
    // MEM-stage event bus
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_ds_i;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic [31:0] exc_badvaddr_i;
    logic        eret_i;

    // CP0 write port and pipeline control
    logic        cp0_we_o;
    logic [4:0]  cp0_waddr_o;
    logic [31:0] cp0_wdata_o;
    logic        flush_o;
    logic        pc_we_o;
    logic [31:0] new_pc_o;
    logic        busy_o;

    // Pipeline side: presents events, consumes writes and redirects
    modport master (
        output mem_valid_i, mem_pc_i, mem_in_ds_i, exc_valid_i,
               exc_code_i, exc_badvaddr_i, eret_i,
        input  cp0_we_o, cp0_waddr_o, cp0_wdata_o, flush_o,
               pc_we_o, new_pc_o, busy_o
    );

    // Sequencer side
    modport slave (
        input  mem_valid_i, mem_pc_i, mem_in_ds_i, exc_valid_i,
               exc_code_i, exc_badvaddr_i, eret_i,
        output cp0_we_o, cp0_waddr_o, cp0_wdata_o, flush_o,
               pc_we_o, new_pc_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_exc_ctrl
//  Description : Exception / interrupt / ERET sequencer between the MEM stage
//                and CP0. Synchronises interrupt lines, prioritises events,
//                drives the single CP0 write port over several cycles while
//                flushing the pipeline, then issues a one-cycle PC redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_exc_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] VEC_OFFSET  = 32'h0000_0180
) (
    input  wire logic        clk,
    input  wire logic        rst,          // asynchronous, active low
    input  wire logic [5:0]  int_i,
    input  wire logic        timer_int_i,
    input  wire logic [31:0] status_i,
    input  wire logic [31:0] cause_i,
    input  wire logic [31:0] epc_i,
    input  wire logic [31:0] ebase_i,
    output logic      [5:0]  hw_int_o,
    cp0_exc_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        S_EPC    = 3'd1,
        S_CAUSE  = 3'd2,
        S_STATUS = 3'd3,
        S_BVA    = 3'd4,
        S_ERET   = 3'd5,
        S_REDIR  = 3'd6
    } state_t;

    localparam logic [4:0] C_REG_BVA    = 5'd8;
    localparam logic [4:0] C_REG_STATUS = 5'd12;
    localparam logic [4:0] C_REG_CAUSE  = 5'd13;
    localparam logic [4:0] C_REG_EPC    = 5'd14;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
    logic [5:0]  hw_int_q, hw_int_d;

    // Event context captured on acceptance
    logic [4:0]  code_q,    code_d;
    logic [31:0] epc_val_q, epc_val_d;
    logic        bd_q,      bd_d;
    logic [31:0] bva_q,     bva_d;
    logic        exl_was_q, exl_was_d;
    logic        eret_q,    eret_d;
    logic [31:0] target_q,  target_d;
    logic [31:0] new_pc_q,  new_pc_d;

    logic        w_int_pend;
    logic [31:0] w_epc_calc;
    logic [31:0] w_vector;
    logic        w_cp0_we;
    logic [4:0]  w_cp0_waddr;
    logic [31:0] w_cp0_wdata;
    logic        w_pc_we;
    logic [31:0] w_new_pc;
    logic        w_busy;

    // Bits of the CP0 inputs this block never looks at
    logic unused_bits;
    assign unused_bits = ^{cause_i[31], cause_i[6:0], ebase_i[11:0]};

    // Shift chain: stage 0 samples the raw lines, the last stage feeds hw_int
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], int_i};
        hw_int_d = {sync_q[SYNC_STAGES-1][5] | timer_int_i,
                    sync_q[SYNC_STAGES-1][4:0]};
    end

    assign w_int_pend = status_i[0] & ~status_i[1]
                      & (|(cause_i[15:8] & status_i[15:8]))
                      & bus.mem_valid_i;
    assign w_epc_calc = bus.mem_in_ds_i ? (bus.mem_pc_i - 32'd4) : bus.mem_pc_i;
    assign w_vector   = {ebase_i[31:12], 12'h000} + VEC_OFFSET;
    assign w_busy     = (state_q != IDLE);

    // Next-state, event latching and Moore outputs of the sequencer
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        epc_val_d   = epc_val_q;
        bd_d        = bd_q;
        bva_d       = bva_q;
        exl_was_d   = exl_was_q;
        eret_d      = eret_q;
        target_d    = target_q;
        w_cp0_we    = 1'b0;
        w_cp0_waddr = 5'd0;
        w_cp0_wdata = 32'd0;
        w_pc_we     = 1'b0;
        w_new_pc    = new_pc_q;

        case (state_q)
            IDLE: begin
                // Exception beats interrupt beats ERET; an interrupt taken
                // over an ERET treats the ERET as the victim instruction.
                if (bus.exc_valid_i || w_int_pend) begin
                    code_d    = bus.exc_valid_i ? bus.exc_code_i : 5'd0;
                    epc_val_d = w_epc_calc;
                    bd_d      = bus.mem_in_ds_i;
                    bva_d     = bus.exc_badvaddr_i;
                    exl_was_d = status_i[1];
                    eret_d    = 1'b0;
                    state_d   = S_EPC;
                end else if (bus.eret_i) begin
                    eret_d    = 1'b1;
                    state_d   = S_ERET;
                end
            end
            S_EPC: begin
                // A nested exception keeps the original EPC
                if (!exl_was_q) begin
                    w_cp0_we    = 1'b1;
                    w_cp0_waddr = C_REG_EPC;
                    w_cp0_wdata = epc_val_q;
                end
                state_d = S_CAUSE;
            end
            S_CAUSE: begin
                w_cp0_we    = 1'b1;
                w_cp0_waddr = C_REG_CAUSE;
                w_cp0_wdata = {bd_q, cause_i[30:7], code_q, 2'b00};
                state_d     = S_STATUS;
            end
            S_STATUS: begin
                w_cp0_we    = 1'b1;
                w_cp0_waddr = C_REG_STATUS;
                w_cp0_wdata = status_i | 32'h0000_0002;
                // Address-error and TLB codes carry a faulting address
                state_d     = ((code_q >= 5'd1) && (code_q <= 5'd5)) ? S_BVA : S_REDIR;
            end
            S_BVA: begin
                w_cp0_we    = 1'b1;
                w_cp0_waddr = C_REG_BVA;
                w_cp0_wdata = bva_q;
                state_d     = S_REDIR;
            end
            S_ERET: begin
                w_cp0_we    = 1'b1;
                w_cp0_waddr = C_REG_STATUS;
                w_cp0_wdata = status_i & ~32'h0000_0002;
                target_d    = epc_i;
                state_d     = S_REDIR;
            end
            S_REDIR: begin
                w_pc_we  = 1'b1;
                w_new_pc = eret_q ? target_q : w_vector;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        new_pc_d = w_new_pc;
    end

    // State, context and synchroniser registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            hw_int_q  <= 6'd0;
            code_q    <= 5'd0;
            epc_val_q <= 32'd0;
            bd_q      <= 1'b0;
            bva_q     <= 32'd0;
            exl_was_q <= 1'b0;
            eret_q    <= 1'b0;
            target_q  <= 32'd0;
            new_pc_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            hw_int_q  <= hw_int_d;
            code_q    <= code_d;
            epc_val_q <= epc_val_d;
            bd_q      <= bd_d;
            bva_q     <= bva_d;
            exl_was_q <= exl_was_d;
            eret_q    <= eret_d;
            target_q  <= target_d;
            new_pc_q  <= new_pc_d;
        end
    end

    assign hw_int_o        = hw_int_q;
    assign bus.cp0_we_o    = w_cp0_we;
    assign bus.cp0_waddr_o = w_cp0_waddr;
    assign bus.cp0_wdata_o = w_cp0_wdata;
    assign bus.flush_o     = w_busy;
    assign bus.busy_o      = w_busy;
    assign bus.pc_we_o     = w_pc_we;
    assign bus.new_pc_o    = w_new_pc;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_exc_ctrl
//  Description : Directed self-checking bench for cp0_exc_ctrl. Expected CP0
//                writes and redirects are queued when an event is presented
//                and popped as the sequencer produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_i;
    logic        timer_int_i;
    logic [31:0] status_i, cause_i, epc_i, ebase_i;
    logic [5:0]  hw_int_o;

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl #(.SYNC_STAGES(2), .VEC_OFFSET(32'h0000_0180)) dut (
        .clk         (clk),
        .rst         (rst),
        .int_i       (int_i),
        .timer_int_i (timer_int_i),
        .status_i    (status_i),
        .cause_i     (cause_i),
        .epc_i       (epc_i),
        .ebase_i     (ebase_i),
        .hw_int_o    (hw_int_o),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_pc;
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_w(input logic [4:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.is_pc = 1'b0; e.addr = a; e.data = d; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic push_pc(input logic [31:0] pc, input int c);
        exp_t e;
        e.is_pc = 1'b1; e.addr = 5'd0; e.data = pc; e.cyc = c;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] exp_cause(input logic bd, input logic [31:0] c,
                                              input logic [4:0] code);
        return {bd, c[30:7], code, 2'b00};
    endfunction

    // Present the event on the next edge, then drop it and make MEM a bubble
    task automatic accept();
        @(posedge clk);
        #1;
        bus.exc_valid_i = 1'b0;
        bus.eret_i      = 1'b0;
        bus.mem_valid_i = 1'b0;
    endtask

    // Observe relative cycles k_from..k_to after acceptance at each negedge
    task automatic drain(input int k_from, input int k_to, input int last_busy);
        exp_t e;
        for (int k = k_from; k <= k_to; k++) begin
            @(negedge clk);
            chk("flush", {31'd0, bus.flush_o}, {31'd0, (k <= last_busy)});
            chk("busy",  {31'd0, bus.busy_o},  {31'd0, (k <= last_busy)});
            if (bus.cp0_we_o || bus.pc_we_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {30'd0, bus.cp0_we_o, bus.pc_we_o}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("event_cycle", k, e.cyc);
                    chk("event_kind", {31'd0, bus.pc_we_o}, {31'd0, e.is_pc});
                    if (e.is_pc) begin
                        chk("new_pc", bus.new_pc_o, e.data);
                    end else begin
                        chk("waddr", {27'd0, bus.cp0_waddr_o}, {27'd0, e.addr});
                        chk("wdata", bus.cp0_wdata_o, e.data);
                    end
                end
            end
        end
    endtask

    task automatic sb_done();
        chk("sb_pending", sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b0;
        int_i              = 6'h3F;
        timer_int_i        = 1'b0;
        status_i           = 32'h1000_0001;
        cause_i            = 32'h4000_0400;
        epc_i              = 32'd0;
        ebase_i            = 32'h8000_0000;
        bus.mem_valid_i    = 1'b1;
        bus.mem_pc_i       = 32'd0;
        bus.mem_in_ds_i    = 1'b0;
        bus.exc_valid_i    = 1'b0;
        bus.exc_code_i     = 5'd0;
        bus.exc_badvaddr_i = 32'd0;
        bus.eret_i         = 1'b0;

        // Reset held with all interrupt lines high
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_hw_int", {26'd0, hw_int_o}, 32'd0);
            chk("rst_flush",  {31'd0, bus.flush_o}, 32'd0);
            chk("rst_we",     {31'd0, bus.cp0_we_o}, 32'd0);
            chk("rst_new_pc", bus.new_pc_o, 32'd0);
        end
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("sync_latency", {26'd0, hw_int_o}, (k == 3) ? 32'h3F : 32'h0);
        end
        int_i = 6'h00;
        repeat (4) @(negedge clk);
        chk("hw_int_clear", {26'd0, hw_int_o}, 32'd0);

        // Overflow, not in a delay slot
        bus.mem_valid_i = 1'b1;  bus.exc_valid_i = 1'b1; bus.exc_code_i = 5'd12;
        bus.mem_pc_i = 32'h8000_0100; bus.mem_in_ds_i = 1'b0;
        status_i = 32'h1000_0001;
        push_w(5'd14, 32'h8000_0100, 1);
        push_w(5'd13, exp_cause(1'b0, cause_i, 5'd12), 2);
        push_w(5'd12, 32'h1000_0003, 3);
        push_pc(32'h8000_0180, 4);
        accept();
        drain(1, 7, 4);
        sb_done();

        // AdEL in a delay slot, BadVAddr written
        bus.mem_valid_i = 1'b1; bus.exc_valid_i = 1'b1; bus.exc_code_i = 5'd4;
        bus.mem_pc_i = 32'h8000_0204; bus.mem_in_ds_i = 1'b1;
        bus.exc_badvaddr_i = 32'h0000_0003;
        push_w(5'd14, 32'h8000_0200, 1);
        push_w(5'd13, exp_cause(1'b1, cause_i, 5'd4), 2);
        push_w(5'd12, 32'h1000_0003, 3);
        push_w(5'd8,  32'h0000_0003, 4);
        push_pc(32'h8000_0180, 5);
        accept();
        drain(1, 8, 5);
        sb_done();

        // AdES at PC 0 in a delay slot: EPC wraps; extra ERET held while busy
        bus.mem_valid_i = 1'b1; bus.exc_valid_i = 1'b1; bus.exc_code_i = 5'd5;
        bus.mem_pc_i = 32'h0000_0000; bus.mem_in_ds_i = 1'b1;
        bus.exc_badvaddr_i = 32'hDEAD_BEEF;
        push_w(5'd14, 32'hFFFF_FFFC, 1);
        push_w(5'd13, exp_cause(1'b1, cause_i, 5'd5), 2);
        push_w(5'd12, 32'h1000_0003, 3);
        push_w(5'd8,  32'hDEAD_BEEF, 4);
        push_pc(32'h8000_0180, 5);
        accept();
        bus.eret_i = 1'b1; bus.exc_valid_i = 1'b1; bus.mem_valid_i = 1'b1;
        drain(1, 3, 5);
        bus.eret_i = 1'b0; bus.exc_valid_i = 1'b0; bus.mem_valid_i = 1'b0;
        drain(4, 8, 5);
        sb_done();

        // Nested exception with EXL already set: EPC write skipped
        bus.mem_valid_i = 1'b1; bus.exc_valid_i = 1'b1; bus.exc_code_i = 5'd10;
        bus.mem_pc_i = 32'h8000_0500; bus.mem_in_ds_i = 1'b0;
        status_i = 32'h1000_0003;
        push_w(5'd13, exp_cause(1'b0, cause_i, 5'd10), 2);
        push_w(5'd12, 32'h1000_0003, 3);
        push_pc(32'h8000_0180, 4);
        accept();
        drain(1, 6, 4);
        sb_done();

        // Timer interrupt wins over a simultaneous ERET
        timer_int_i = 1'b1; status_i = 32'h1000_8001; cause_i = 32'h0000_8000;
        bus.mem_valid_i = 1'b1; bus.eret_i = 1'b1; bus.exc_valid_i = 1'b0;
        bus.mem_pc_i = 32'h8000_0300; bus.mem_in_ds_i = 1'b0;
        epc_i = 32'h1234_5678;
        push_w(5'd14, 32'h8000_0300, 1);
        push_w(5'd13, exp_cause(1'b0, cause_i, 5'd0), 2);
        push_w(5'd12, 32'h1000_8003, 3);
        push_pc(32'h8000_0180, 4);
        accept();
        chk("timer_ip7", {26'd0, hw_int_o}, 32'h20);
        drain(1, 7, 4);
        sb_done();

        // Same interrupt with EXL set, and with a bubble in MEM: no action
        status_i = 32'h1000_8003; bus.mem_valid_i = 1'b1;
        drain(1, 3, 0);
        status_i = 32'h1000_8001; bus.mem_valid_i = 1'b0;
        drain(1, 3, 0);
        sb_done();
        timer_int_i = 1'b0; cause_i = 32'h4000_0400;

        // ERET
        status_i = 32'h1000_0003; epc_i = 32'h8000_0400;
        bus.mem_valid_i = 1'b1; bus.eret_i = 1'b1;
        push_w(5'd12, 32'h1000_0001, 1);
        push_pc(32'h8000_0400, 2);
        accept();
        drain(1, 5, 2);
        sb_done();
        chk("new_pc_hold", bus.new_pc_o, 32'h8000_0400);

        // Reset asserted during the Cause write
        status_i = 32'h1000_0001;
        bus.mem_valid_i = 1'b1; bus.exc_valid_i = 1'b1; bus.exc_code_i = 5'd12;
        bus.mem_pc_i = 32'h8000_0600; bus.mem_in_ds_i = 1'b0;
        push_w(5'd14, 32'h8000_0600, 1);
        push_w(5'd13, exp_cause(1'b0, cause_i, 5'd12), 2);
        accept();
        drain(1, 2, 99);
        sb_done();
        rst = 1'b0;
        #1;
        chk("abort_we",     {31'd0, bus.cp0_we_o}, 32'd0);
        chk("abort_flush",  {31'd0, bus.flush_o}, 32'd0);
        chk("abort_busy",   {31'd0, bus.busy_o}, 32'd0);
        chk("abort_pc_we",  {31'd0, bus.pc_we_o}, 32'd0);
        chk("abort_new_pc", bus.new_pc_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drain(1, 6, 0);
        sb_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
